// File: rtl/hdmi_video_timing_gen.sv
// Raster timing, video preamble/guard band and 8-bar colour pattern for the
// HDMI colour-bar source. All outputs are registered and describe (h_pos, v_pos).
module hdmi_video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        pixel_clk,
    input  logic        n_rst,
    input  logic        en,
    output logic        hsync,
    output logic        vsync,
    output logic        active_video,
    output logic        video_gb,
    output logic        data_island_gb,
    output logic [3:0]  ctl,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start,
    output logic [11:0] h_pos,
    output logic [10:0] v_pos
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
    localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST    = 12'(H_TOTAL - 1);
    localparam logic [11:0] PRE_START = 12'(H_TOTAL - 10);
    localparam logic [11:0] PRE_END   = 12'(H_TOTAL - 3);
    localparam logic [11:0] GB_START  = 12'(H_TOTAL - 2);
    localparam logic [11:0] BAR_LAST  = 12'(BAR_W - 1);

    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_PRE_LAST = 11'(V_ACTIVE - 2);

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic [11:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;

    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        active_q, active_d;
    logic        video_gb_q, video_gb_d;
    logic [3:0]  ctl_q, ctl_d;
    logic [23:0] rgb_q, rgb_d;
    logic        frame_start_q, frame_start_d;
    logic [11:0] h_pos_q, h_pos_d;
    logic [10:0] v_pos_q, v_pos_d;

    logic        pre_line;
    logic [23:0] bar_rgb;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        h_cnt_d   = '0;
        v_cnt_d   = '0;
        bar_cnt_d = '0;
        bar_idx_d = '0;
        if (en) begin
            h_cnt_d   = h_cnt_q + 12'd1;
            v_cnt_d   = v_cnt_q;
            bar_cnt_d = bar_cnt_q;
            bar_idx_d = bar_idx_q;
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
            end
            if (h_cnt_q == H_LAST) begin
                bar_cnt_d = '0;
                bar_idx_d = '0;
            end else if (h_cnt_q < H_ACT) begin
                if (bar_cnt_q == BAR_LAST) begin
                    bar_cnt_d = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + 12'd1;
                end
            end
        end
    end

    always_comb begin
        unique case (bar_idx_q)
            3'd0:    bar_rgb = 24'hFF_FF_FF;
            3'd1:    bar_rgb = 24'hFF_FF_00;
            3'd2:    bar_rgb = 24'h00_FF_FF;
            3'd3:    bar_rgb = 24'h00_FF_00;
            3'd4:    bar_rgb = 24'hFF_00_FF;
            3'd5:    bar_rgb = 24'hFF_00_00;
            3'd6:    bar_rgb = 24'h00_00_FF;
            default: bar_rgb = 24'h00_00_00;
        endcase
    end

    // Preamble and guard band precede every active line, including line 0 of the next frame.
    assign pre_line = (v_cnt_q == V_LAST) || (v_cnt_q <= V_PRE_LAST);

    always_comb begin
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        active_d      = 1'b0;
        video_gb_d    = 1'b0;
        ctl_d         = 4'b0000;
        rgb_d         = '0;
        frame_start_d = 1'b0;
        h_pos_d       = '0;
        v_pos_d       = '0;
        if (en) begin
            if (h_cnt_q >= HS_START && h_cnt_q < HS_END) hsync_d = HS_POL;
            if (v_cnt_q >= VS_START && v_cnt_q < VS_END) vsync_d = VS_POL;
            active_d = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
            if (active_d) rgb_d = bar_rgb;
            if (pre_line && h_cnt_q >= PRE_START && h_cnt_q <= PRE_END) ctl_d = 4'b0001;
            video_gb_d    = pre_line && (h_cnt_q >= GB_START);
            frame_start_d = (h_cnt_q == 12'd0) && (v_cnt_q == 11'd0);
            h_pos_d       = h_cnt_q;
            v_pos_d       = v_cnt_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge pixel_clk or negedge n_rst) begin
        if (!n_rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            bar_cnt_q     <= '0;
            bar_idx_q     <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            active_q      <= 1'b0;
            video_gb_q    <= 1'b0;
            ctl_q         <= 4'b0000;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            h_pos_q       <= '0;
            v_pos_q       <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            bar_cnt_q     <= bar_cnt_d;
            bar_idx_q     <= bar_idx_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            video_gb_q    <= video_gb_d;
            ctl_q         <= ctl_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            h_pos_q       <= h_pos_d;
            v_pos_q       <= v_pos_d;
        end
    end

    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
    assign active_video   = active_q;
    assign video_gb       = video_gb_q;
    assign data_island_gb = 1'b0;
    assign ctl            = ctl_q;
    assign red            = rgb_q[23:16];
    assign green          = rgb_q[15:8];
    assign blue           = rgb_q[7:0];
    assign frame_start    = frame_start_q;
    assign h_pos          = h_pos_q;
    assign v_pos          = v_pos_q;

endmodule
